main_mem_arbiter: RTL and testbench

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

---
 rtl/core_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 16 +
 rtl/main_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_main_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared arbiter types: FSM states, requester IDs and the read-return tag.
package core_pkg;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_YIELD  = 2'd2
    } arb_state_e;

    typedef enum logic {
        ID_CORE = 1'b0,
        ID_LDR  = 1'b1
    } req_id_e;

    // Bit positions of each requester in the two-bit request/grant vectors.
    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_LDR  = 1;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rtag_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on conflict the one not granted last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_ldr_i,
    output logic [1:0] gnt_o
);

    // Pass through single requests; break ties against the previous winner.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_ldr_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Main-memory arbiter between the core memory stage and the loader, with locked loader bursts.
module main_mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic              ldr_lock,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    req_id_e            last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    rtag_t              tag_q, tag_d;
    logic [1:0]         rr_gnt;

    rr_pick2 u_rr_pick2 (
        .req_i      ({ldr_req, core_req}),
        .last_ldr_i (last_q == ID_LDR),
        .gnt_o      (rr_gnt)
    );

    // State register, round-robin history, burst counter and read-return tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            last_q  <= ID_LDR;
            burst_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            tag_q   <= tag_d;
        end
    end

    // Next state and grants; grants are suppressed while reset is held.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        burst_d  = burst_q;
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_ARB: begin
                    core_gnt = rr_gnt[REQ_CORE];
                    ldr_gnt  = rr_gnt[REQ_LDR];
                    burst_d  = '0;
                    if (ldr_gnt && ldr_lock) begin
                        burst_d = BURST_W'(1);
                        state_d = (burst_d == BURST_W'(MAX_BURST)) ? ST_YIELD : ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    ldr_gnt = ldr_req;
                    if (ldr_gnt) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                    // Dropping the lock ends the burst even if this cycle's grant would fill it.
                    if (!ldr_lock) begin
                        state_d = ST_ARB;
                        burst_d = '0;
                    end else if (ldr_gnt && (burst_d == BURST_W'(MAX_BURST))) begin
                        state_d = ST_YIELD;
                    end
                end
                ST_YIELD: begin
                    core_gnt = core_req;
                    state_d  = ST_ARB;
                    burst_d  = '0;
                end
                default: begin
                    state_d = ST_ARB;
                    burst_d = '0;
                end
            endcase
            if (core_gnt) begin
                last_d = ID_CORE;
            end else if (ldr_gnt) begin
                last_d = ID_LDR;
            end
        end
    end

    // Steer the granted requester onto the RAM port and capture the read tag.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_d     = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            tag_d     = '{valid: !core_we, id: ID_CORE};
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            tag_d     = '{valid: !ldr_we, id: ID_LDR};
        end
    end

    // Route the RAM read data to whichever requester owns the returning tag.
    always_comb begin
        core_stall  = core_req && !core_gnt && !reset;
        core_rvalid = tag_q.valid && (tag_q.id == ID_CORE);
        ldr_rvalid  = tag_q.valid && (tag_q.id == ID_LDR);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        ldr_rdata   = ldr_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_main_mem_arbiter;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, ldr_req, ldr_we, ldr_lock;
    logic [7:0]  core_addr, ldr_addr, mem_addr;
    logic [15:0] core_wdata, ldr_wdata, mem_wdata, mem_rdata;
    logic        core_gnt, core_stall, core_rvalid, ldr_gnt, ldr_rvalid, mem_we;
    logic [15:0] core_rdata, ldr_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ram [256];

    main_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model state: mode 0 = free arbitration, 1 = locked burst, 2 = forced yield to core.
    int          m_mode, m_run;
    bit          m_core_last;
    bit          p_core, p_ldr;
    logic [15:0] p_data;
    bit          e_c, e_l, e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;

    // Per-cycle comparison against the model, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_core_gnt", core_gnt, 0);     chk("rst_ldr_gnt", ldr_gnt, 0);
            chk("rst_stall", core_stall, 0);      chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);     chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_core_rvalid", core_rvalid, 0); chk("rst_core_rdata", core_rdata, 0);
            chk("rst_ldr_rvalid", ldr_rvalid, 0); chk("rst_ldr_rdata", ldr_rdata, 0);
            m_mode = 0; m_run = 0; m_core_last = 1'b0; p_core = 1'b0; p_ldr = 1'b0; p_data = '0;
        end else begin
            e_c = 1'b0; e_l = 1'b0;
            if (m_mode == 0) begin
                if (core_req && ldr_req) begin
                    e_c = !m_core_last; e_l = m_core_last;
                end else begin
                    e_c = core_req; e_l = ldr_req;
                end
            end else if (m_mode == 1) e_l = ldr_req;
            else e_c = core_req;
            e_we   = e_c ? core_we : (e_l ? ldr_we : 1'b0);
            e_addr = e_c ? core_addr : (e_l ? ldr_addr : 8'h00);
            e_wd   = e_c ? core_wdata : (e_l ? ldr_wdata : 16'h0000);
            chk("core_gnt", core_gnt, e_c);       chk("ldr_gnt", ldr_gnt, e_l);
            chk("core_stall", core_stall, core_req && !e_c);
            chk("mem_we", mem_we, e_we);          chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("core_rvalid", core_rvalid, p_core); chk("core_rdata", core_rdata, p_core ? p_data : 16'h0);
            chk("ldr_rvalid", ldr_rvalid, p_ldr);    chk("ldr_rdata", ldr_rdata, p_ldr ? p_data : 16'h0);
            p_core = e_c && !core_we;
            p_ldr  = e_l && !ldr_we;
            p_data = ram[e_addr];
            if (e_c) m_core_last = 1'b1;
            else if (e_l) m_core_last = 1'b0;
            case (m_mode)
                0: if (e_l && ldr_lock) begin m_run = 1; m_mode = (m_run == MAXB) ? 2 : 1; end
                1: begin
                    if (e_l) m_run++;
                    if (!ldr_lock) begin m_mode = 0; m_run = 0; end
                    else if (e_l && m_run == MAXB) m_mode = 2;
                end
                default: begin m_mode = 0; m_run = 0; end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                         input logic lr, input logic lw, input logic lk, input logic [7:0] la,
                         input logic [15:0] ld);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_lock = lk; ldr_addr = la; ldr_wdata = ld;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); step();
        reset = 1'b0; step();
    endtask

    bit g_c [20];
    bit g_l [20];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h10] = 16'hBEEF;
        reset = 1'b1;
        idle();
        step(); step();

        // Requests during reset must not be granted.
        drive(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h11, 16'h0);
        #1;
        chk("lit_rst_core_gnt", core_gnt, 0);
        chk("lit_rst_ldr_gnt", ldr_gnt, 0);
        step();
        reset = 1'b0; idle(); step();

        // Lone core read of 0x10 returning 0xBEEF.
        drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        #1;
        chk("lit_rd_gnt", core_gnt, 1);
        chk("lit_rd_addr", mem_addr, 8'h10);
        step(); idle(); #1;
        chk("lit_rd_rvalid", core_rvalid, 1);
        chk("lit_rd_rdata", core_rdata, 16'hBEEF);
        chk("lit_rd_ldr_rvalid", ldr_rvalid, 0);
        chk("lit_rd_ldr_rdata", ldr_rdata, 0);
        step();

        // Loader write 0x1234 to 0x05, then read it back.
        drive(0, 0, 8'h00, 16'h0, 1, 1, 0, 8'h05, 16'h1234);
        #1;
        chk("lit_wr_we", mem_we, 1);
        chk("lit_wr_addr", mem_addr, 8'h05);
        chk("lit_wr_wdata", mem_wdata, 16'h1234);
        step(); idle(); #1;
        chk("lit_wr_no_rvalid", ldr_rvalid, 0);
        step();
        drive(0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0);
        step(); idle(); #1;
        chk("lit_ldr_rdata", ldr_rdata, 16'h1234);
        step();

        // Both requesting without lock after reset: core, loader, core, ...
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 8'(8'h40 + i), 16'h0, 1, 0, 0, 8'(8'h50 + i), 16'h0);
            #1;
            chk("lit_alt_core", core_gnt, (i % 2 == 0));
            chk("lit_alt_stall", core_stall, (i % 2 == 1));
            step();
        end
        idle(); step();

        // Locked loader burst of 20 writes against a requesting core.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(i != 0, 0, 8'h10, 16'h0, 1, 1, 1, 8'(8'h80 + i), 16'(i));
            #1;
            g_c[i] = core_gnt; g_l[i] = ldr_gnt;
            step();
        end
        idle(); step();
        begin
            int nl, fc;
            nl = 0; fc = -1;
            for (int i = 0; i < 16; i++) nl += int'(g_l[i]);
            for (int i = 19; i >= 0; i--) if (g_c[i]) fc = i;
            chk("lit_burst_ldr_grants", 32'(nl), 16);
            chk("lit_yield_core_idx", 32'(fc), 16);
            chk("lit_yield_no_ldr", g_l[16], 0);
            chk("lit_arb_resume_ldr", g_l[17], 1);
        end

        // Short lock burst of 3 with a dropped request mid-burst, then lock released.
        do_reset();
        drive(0, 0, 8'h00, 16'h0, 1, 1, 1, 8'h30, 16'hA000); #1;
        chk("lit_lk3_g0", ldr_gnt, 1); step();
        drive(1, 0, 8'h10, 16'h0, 1, 1, 1, 8'h31, 16'hA001); #1;
        chk("lit_lk3_g1", ldr_gnt, 1); step();
        drive(1, 0, 8'h10, 16'h0, 0, 0, 1, 8'h00, 16'h0); #1;
        chk("lit_lk3_hold_nogrant", ldr_gnt, 0);
        chk("lit_lk3_hold_stall", core_stall, 1); step();
        drive(1, 0, 8'h10, 16'h0, 1, 1, 1, 8'h32, 16'hA002); #1;
        chk("lit_lk3_g2", ldr_gnt, 1); step();
        drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0); #1;
        chk("lit_lk3_unlock_core", core_gnt, 0); step();
        drive(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h30, 16'h0); #1;
        chk("lit_lk3_conflict_core", core_gnt, 1); step();
        idle(); step();

        // Reset right after a core read grant discards the return.
        do_reset();
        drive(0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0); step();
        drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0); #1;
        chk("lit_rr_gnt", core_gnt, 1); step();
        reset = 1'b1; idle(); #1;
        chk("lit_rr_no_rvalid", core_rvalid, 0);
        chk("lit_rr_rdata0", core_rdata, 0);
        step();
        reset = 1'b0;
        drive(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h05, 16'h0); #1;
        chk("lit_rr_first_core", core_gnt, 1);
        chk("lit_rr_first_ldr", ldr_gnt, 0);
        step();
        idle(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
